cpu_controller: RTL

- Multicycle control FSM for the 8-bit two-byte-instruction CPU.
- Drives every select and enable of the datapath.
- Sequences fetch of instruction byte 1 (IR1) and byte 2 (IR2), then one execute state per instruction.
- Handles memory wait states through a ready handshake; sits beside the datapath in the CPU top.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_ctrl_decode.sv | 35 +++
 rtl/cpu_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle CPU controller.
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH1,
    FETCH2,
    EXEC_ALU,
    EXEC_INC,
    MEM_LOAD,
    MEM_STORE,
    JUMP,
    JZ,
    HALT
  } state_t;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h2;
  localparam logic [OP_W-1:0] OP_AND   = 4'h3;
  localparam logic [OP_W-1:0] OP_OR    = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h5;
  localparam logic [OP_W-1:0] OP_INC   = 4'h6;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h8;
  localparam logic [OP_W-1:0] OP_STORE = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP   = 4'hA;
  localparam logic [OP_W-1:0] OP_JZ    = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Opcode decoder: execute state, ALU operation and illegal flag.
// CPU_CTRL_JZ_EN adds the JZ opcode; otherwise 0xB decodes as illegal.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output state_t     exec_state,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    exec_state = FETCH1;
    alu_ctrl   = ALU_ADD;
    illegal    = 1'b0;
    case (opcode)
      OP_NOP:   exec_state = FETCH1;
      OP_ADD:   begin exec_state = EXEC_ALU; alu_ctrl = ALU_ADD; end
      OP_SUB:   begin exec_state = EXEC_ALU; alu_ctrl = ALU_SUB; end
      OP_AND:   begin exec_state = EXEC_ALU; alu_ctrl = ALU_AND; end
      OP_OR:    begin exec_state = EXEC_ALU; alu_ctrl = ALU_OR;  end
      OP_XOR:   begin exec_state = EXEC_ALU; alu_ctrl = ALU_XOR; end
      OP_INC:   exec_state = EXEC_INC;
      OP_LOAD:  exec_state = MEM_LOAD;
      OP_STORE: exec_state = MEM_STORE;
      OP_JMP:   exec_state = JUMP;
`ifdef CPU_CTRL_JZ_EN
      OP_JZ:    exec_state = JZ;
`endif
      OP_HALT:  exec_state = HALT;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM for the 8-bit two-byte-instruction CPU.
// Optional JZ instruction and zero flag enabled by CPU_CTRL_JZ_EN.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter bit RESET_PC_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic [7:0] aluout,
  input  logic       memReady,
  output logic       pcSelect,
  output logic       pcEnable,
  output logic       adrSelect,
  output logic       ir1En,
  output logic       ir2En,
  output logic       regSelect,
  output logic       wd3Select,
  output logic       regWrite,
  output logic       op1Sel,
  output logic       op2Sel,
  output logic       aluOutEn,
  output logic [2:0] aluControl,
  output logic       memWrite,
  output logic       halted,
  output logic       illegal
);

  localparam state_t RST_STATE = RESET_PC_HOLD ? IDLE : FETCH1;

  state_t     state_q, state_d;
  state_t     dec_state;
  logic [2:0] dec_alu;
  logic       dec_illegal;

  cpu_ctrl_decode u_decode (
    .opcode     (opcode),
    .exec_state (dec_state),
    .alu_ctrl   (dec_alu),
    .illegal    (dec_illegal)
  );

`ifdef CPU_CTRL_JZ_EN
  logic zero_q, zero_d;

  // Flag tracks the result of the last register-writing ALU/INC instruction
  always_comb begin
    zero_d = zero_q;
    if (state_q == EXEC_ALU || state_q == EXEC_INC) zero_d = (aluout == 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) zero_q <= 1'b0;
    else       zero_q <= zero_d;
  end
`else
  logic unused_aluout;
  assign unused_aluout = ^aluout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcSelect   = 1'b0;
    pcEnable   = 1'b0;
    adrSelect  = 1'b0;
    ir1En      = 1'b0;
    ir2En      = 1'b0;
    regSelect  = 1'b0;
    wd3Select  = 1'b0;
    regWrite   = 1'b0;
    op1Sel     = 1'b0;
    op2Sel     = 1'b0;
    aluOutEn   = 1'b0;
    aluControl = ALU_ADD;
    memWrite   = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = FETCH1;
      FETCH1: begin
        op2Sel = 1'b1;
        if (memReady) begin
          ir1En    = 1'b1;
          pcEnable = 1'b1;
          state_d  = FETCH2;
        end
      end
      FETCH2: begin
        op2Sel = 1'b1;
        if (memReady) begin
          ir2En    = 1'b1;
          pcEnable = 1'b1;
          illegal  = dec_illegal;
          state_d  = dec_state;
        end
      end
      EXEC_ALU: begin
        regSelect  = 1'b1;
        op1Sel     = 1'b1;
        wd3Select  = 1'b1;
        regWrite   = 1'b1;
        aluOutEn   = 1'b1;
        aluControl = dec_alu;
        state_d    = FETCH1;
      end
      EXEC_INC: begin
        op1Sel    = 1'b1;
        op2Sel    = 1'b1;
        wd3Select = 1'b1;
        regWrite  = 1'b1;
        aluOutEn  = 1'b1;
        state_d   = FETCH1;
      end
      MEM_LOAD: begin
        adrSelect = 1'b1;
        if (memReady) begin
          regWrite = 1'b1;
          state_d  = FETCH1;
        end
      end
      MEM_STORE: begin
        adrSelect = 1'b1;
        memWrite  = 1'b1;
        if (memReady) state_d = FETCH1;
      end
      JUMP: begin
        pcSelect = 1'b1;
        pcEnable = 1'b1;
        state_d  = FETCH1;
      end
`ifdef CPU_CTRL_JZ_EN
      JZ: begin
        pcSelect = 1'b1;
        pcEnable = zero_q;
        state_d  = FETCH1;
      end
`endif
      HALT: halted = 1'b1;
      default: state_d = FETCH1;
    endcase
    // Nothing may write or strobe while reset is held
    if (reset) begin
      pcEnable = 1'b0;
      ir1En    = 1'b0;
      ir2En    = 1'b0;
      regWrite = 1'b0;
      aluOutEn = 1'b0;
      memWrite = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
